// File: rtl/deskew_pkg.sv
// ---------------------------------------------------------------------------
// deskew_pkg
// Shared definitions for the deskew frame sequencing logic.
//   DIM_W, ACC_W  : default widths of the image dimension and accumulator
//   SAMPLE_CNT_W  : width of a full-frame sample count, (dim+1)^2
//   scan_state_e  : xp_scan_ctrl state encoding
// ---------------------------------------------------------------------------
package deskew_pkg;

  localparam int DIM_W        = 9;
  localparam int ACC_W        = 24;
  localparam int SAMPLE_CNT_W = 2 * DIM_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FLUSH = 3'd4
  } scan_state_e;

endpackage

// File: rtl/scan_sample_chk.sv
// ---------------------------------------------------------------------------
// scan_sample_chk
// Independent accept counter for one frame. When the sequencer enters DONE
// the number of accepted samples is compared with (img_dim+1)^2 and a sticky
// error flag is raised on mismatch. The flag clears on the next start-accept.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_acc   : start accepted in IDLE (clears err)
//   clr         : sequencer is in CLEAR (clears the counter)
//   accept      : one sample accepted this cycle
//   done_entry  : this cycle's accept is the last one, DONE follows
//   img_dim     : shadowed frame dimension
//   err         : sticky sample-count mismatch flag
// ---------------------------------------------------------------------------
module scan_sample_chk #(
  parameter int DIM_W = deskew_pkg::DIM_W,
  parameter int CNT_W = deskew_pkg::SAMPLE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_acc,
  input  logic             clr,
  input  logic             accept,
  input  logic             done_entry,
  input  logic [DIM_W-1:0] img_dim,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Square truncated to the counter width, so both wrap identically.
  function automatic logic [CNT_W-1:0] square_cnt(input logic [CNT_W-1:0] v);
    return v * v;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] target_s;
  logic             err_r;

  // Expected sample count and the count including the current accept.
  always_comb begin
    cnt_inc_s = cnt_r + CNT_ONE;
    target_s  = square_cnt(CNT_W'(img_dim) + CNT_ONE);
  end

  // Accept counter, cleared while the generator is being cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept) begin
      cnt_r <= cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky mismatch flag; the final accept is already included via cnt_inc_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start_acc) begin
      err_r <= 1'b0;
    end else if (done_entry && (cnt_inc_s != target_s)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;

endmodule

// File: rtl/xp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// xp_scan_ctrl
// Frame sequencer for one xp_gen coordinate/skew-accumulator generator.
// A start in IDLE latches cfg_* into shadow registers, clears the generator
// for one cycle, then steps it once per accepted beat (out_valid & out_ready)
// until the sample at (img_dim, img_dim) is accepted, then pulses done.
// abort sends any active state to FLUSH, which clears the generator again.
//
// Optional build macro XP_SCAN_CTRL_CHK_EN adds scan_sample_chk, which
// flags a wrong sample count at frame end on err; otherwise err is 0.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : frame start request / frame termination
//   cfg_img_dim/incr/offset : per-frame configuration (sampled at start)
//   x_cnt_xp, y_cnt_xp    : generator coordinate counters
//   out_ready             : downstream accepts the current sample
//   gen_en, gen_sclr      : generator step enable / synchronous clear
//   gen_img_dim/incr/offset : shadowed configuration to the generator
//   out_valid             : generator output is a valid sample
//   busy, done, err       : frame active / completion pulse / count error
// ---------------------------------------------------------------------------
module xp_scan_ctrl #(
  parameter int DIM_W = deskew_pkg::DIM_W,
  parameter int ACC_W = deskew_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] cfg_img_dim,
  input  logic [ACC_W-1:0] cfg_incr,
  input  logic [ACC_W-1:0] cfg_offset,
  input  logic [DIM_W-1:0] x_cnt_xp,
  input  logic [DIM_W-1:0] y_cnt_xp,
  input  logic             out_ready,
  output logic             gen_en,
  output logic             gen_sclr,
  output logic [DIM_W-1:0] gen_img_dim,
  output logic [ACC_W-1:0] gen_incr,
  output logic [ACC_W-1:0] gen_offset,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  import deskew_pkg::*;

  scan_state_e      state_r;
  scan_state_e      state_nxt_s;
  logic [DIM_W-1:0] img_dim_r;
  logic [ACC_W-1:0] incr_r;
  logic [ACC_W-1:0] offset_r;
  logic             gen_sclr_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             done_r;
  logic             start_acc_s;
  logic             accept_s;
  logic             last_s;

  // out_valid_r is high exactly in RUN; abort suppresses the step that cycle.
  assign accept_s    = out_valid_r & out_ready & ~abort;
  assign last_s      = (x_cnt_xp == img_dim_r) && (y_cnt_xp == img_dim_r);
  assign start_acc_s = (state_r == ST_IDLE) & start & ~abort;

  // Next-state decode; abort wins over every other transition.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_acc_s) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_FLUSH;
        end else if (accept_s && last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, registered state-decoded outputs and configuration shadows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      gen_sclr_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      img_dim_r   <= {DIM_W{1'b0}};
      incr_r      <= {ACC_W{1'b0}};
      offset_r    <= {ACC_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      gen_sclr_r  <= (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_FLUSH);
      out_valid_r <= (state_nxt_s == ST_RUN);
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= (state_nxt_s == ST_DONE);
      if (start_acc_s) begin
        img_dim_r <= cfg_img_dim;
        incr_r    <= cfg_incr;
        offset_r  <= cfg_offset;
      end else begin
        img_dim_r <= img_dim_r;
        incr_r    <= incr_r;
        offset_r  <= offset_r;
      end
    end
  end

  assign gen_en      = accept_s;
  assign gen_sclr    = gen_sclr_r;
  assign gen_img_dim = img_dim_r;
  assign gen_incr    = incr_r;
  assign gen_offset  = offset_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign done        = done_r;

`ifdef XP_SCAN_CTRL_CHK_EN
  logic clr_s;
  logic done_entry_s;

  assign clr_s        = (state_r == ST_CLEAR);
  assign done_entry_s = (state_r == ST_RUN) & accept_s & last_s;

  scan_sample_chk #(
    .DIM_W (DIM_W),
    .CNT_W (2 * DIM_W)
  ) u_sample_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_acc  (start_acc_s),
    .clr        (clr_s),
    .accept     (accept_s),
    .done_entry (done_entry_s),
    .img_dim    (img_dim_r),
    .err        (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_xp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xp_scan_ctrl
// Self-checking bench for xp_scan_ctrl with a small behavioural xp_gen
// coordinate model. Table-driven frames plus hand-written sequences for
// start/abort collision, mid-frame abort, forced count mismatch and reset.
// ---------------------------------------------------------------------------
module tb_xp_scan_ctrl;

  localparam int DIM_W = 9;
  localparam int ACC_W = 24;

`ifdef XP_SCAN_CTRL_CHK_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [DIM_W-1:0] cfg_img_dim;
  logic [ACC_W-1:0] cfg_incr;
  logic [ACC_W-1:0] cfg_offset;
  logic [DIM_W-1:0] x_cnt_xp;
  logic [DIM_W-1:0] y_cnt_xp;
  logic             out_ready;
  logic             gen_en;
  logic             gen_sclr;
  logic [DIM_W-1:0] gen_img_dim;
  logic [ACC_W-1:0] gen_incr;
  logic [ACC_W-1:0] gen_offset;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  // generator model and optional x/y override
  logic             force_xy;
  logic [DIM_W-1:0] gx_r;
  logic [DIM_W-1:0] gy_r;

  assign x_cnt_xp = force_xy ? 9'd1 : gx_r;
  assign y_cnt_xp = force_xy ? 9'd1 : gy_r;

  xp_scan_ctrl #(.DIM_W(DIM_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_img_dim (cfg_img_dim),
    .cfg_incr    (cfg_incr),
    .cfg_offset  (cfg_offset),
    .x_cnt_xp    (x_cnt_xp),
    .y_cnt_xp    (y_cnt_xp),
    .out_ready   (out_ready),
    .gen_en      (gen_en),
    .gen_sclr    (gen_sclr),
    .gen_img_dim (gen_img_dim),
    .gen_incr    (gen_incr),
    .gen_offset  (gen_offset),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // raster-order coordinate generator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_r <= 9'd0;
      gy_r <= 9'd0;
    end else if (gen_sclr) begin
      gx_r <= 9'd0;
      gy_r <= 9'd0;
    end else if (gen_en) begin
      if (gx_r == gen_img_dim) begin
        gx_r <= 9'd0;
        gy_r <= gy_r + 9'd1;
      end else begin
        gx_r <= gx_r + 9'd1;
      end
    end
  end

  typedef struct {
    logic [DIM_W-1:0] dim;
    logic [ACC_W-1:0] incr;
    logic [ACC_W-1:0] offset;
    logic [3:0]       pat;       // ready pattern, bit k used in RUN cycle k mod 4
    int               exp_acc;
    int               exp_done;  // cycle of done, start-accept edge = cycle 0
  } frame_t;

  frame_t frames [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame from start to busy falling; poke pulses start and changes cfg mid-frame.
  task automatic run_frame(input frame_t f, input logic poke);
    int               acc;
    int               done_cnt;
    int               done_cyc;
    logic [DIM_W-1:0] lx;
    logic [DIM_W-1:0] ly;
    logic [DIM_W-1:0] hx;
    logic [DIM_W-1:0] hy;
    logic             stalled;
    acc = 0; done_cnt = 0; done_cyc = 0; lx = '0; ly = '0; hx = '0; hy = '0; stalled = 1'b0;
    start = 1'b1; cfg_img_dim = f.dim; cfg_incr = f.incr; cfg_offset = f.offset;
    step();
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      out_ready = (c >= 2) ? f.pat[(c - 2) % 4] : 1'b1;
      if (poke && c == 4 && c < f.exp_done) begin
        start = 1'b1; cfg_img_dim = f.dim + 9'd3; cfg_incr = ~f.incr; cfg_offset = ~f.offset;
      end else begin
        start = 1'b0;
      end
      #1;
      if (c == 1) begin
        check("clear_sclr", 32'(gen_sclr), 32'd1);
        check("clear_valid", 32'(out_valid), 32'd0);
        check("clear_busy", 32'(busy), 32'd1);
        check("shadow_dim", 32'(gen_img_dim), 32'(f.dim));
        check("shadow_incr", 32'(gen_incr), 32'(f.incr));
        check("shadow_offset", 32'(gen_offset), 32'(f.offset));
      end
      if (stalled) begin
        check("stall_x", 32'(x_cnt_xp), 32'(hx));
        check("stall_y", 32'(y_cnt_xp), 32'(hy));
      end
      stalled = out_valid && !out_ready;
      hx = x_cnt_xp; hy = y_cnt_xp;
      if (out_valid && out_ready) begin
        acc++; lx = x_cnt_xp; ly = y_cnt_xp;
      end
      if (done) begin
        done_cnt++; done_cyc = c;
      end
      if (done_cyc != 0 && c == done_cyc + 1) begin
        check("busy_after_done", 32'(busy), 32'd0);
        break;
      end
      step();
    end
    start = 1'b0; cfg_img_dim = f.dim; cfg_incr = f.incr; cfg_offset = f.offset;
    check("accepts", 32'(acc), 32'(f.exp_acc));
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'(f.exp_done));
    check("last_x", 32'(lx), 32'(f.dim));
    check("last_y", 32'(ly), 32'(f.dim));
    check("cfg_ignored_dim", 32'(gen_img_dim), 32'(f.dim));
    check("cfg_ignored_incr", 32'(gen_incr), 32'(f.incr));
    check("err_clean", 32'(err), 32'd0);
  endtask

  // Start a frame with ready held and return once n accepts are committed.
  task automatic run_accepts(input logic [DIM_W-1:0] dim, input int n);
    int acc;
    acc = 0;
    start = 1'b1; cfg_img_dim = dim; cfg_incr = 24'h000001; cfg_offset = 24'h000000;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 100 && acc < n; c++) begin
      #1;
      if (out_valid && out_ready) acc++;
      step();
    end
    check("accepts_reached", 32'(acc), 32'(n));
  endtask

  initial begin
    frames[0] = '{dim: 9'd3, incr: 24'h000100, offset: 24'h000010, pat: 4'b1111, exp_acc: 16, exp_done: 18};
    frames[1] = '{dim: 9'd2, incr: 24'h000200, offset: 24'h000020, pat: 4'b1001, exp_acc: 9,  exp_done: 19};
    frames[2] = '{dim: 9'd0, incr: 24'h123456, offset: 24'h00abcd, pat: 4'b1111, exp_acc: 1,  exp_done: 3};
    frames[3] = '{dim: 9'd1, incr: 24'h000001, offset: 24'h000002, pat: 4'b1111, exp_acc: 4,  exp_done: 6};
    frames[4] = '{dim: 9'd1, incr: 24'hfedcba, offset: 24'h100000, pat: 4'b1110, exp_acc: 4,  exp_done: 8};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; force_xy = 1'b0;
    cfg_img_dim = 9'd0; cfg_incr = 24'h0; cfg_offset = 24'h0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sclr", 32'(gen_sclr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dim", 32'(gen_img_dim), 32'd0);
    rst_n = 1'b1;
    step();

    // start together with abort in IDLE is dropped
    start = 1'b1; abort = 1'b1; cfg_img_dim = 9'd7; cfg_incr = 24'h00aaaa;
    step();
    start = 1'b0; abort = 1'b0;
    #1;
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_sclr", 32'(gen_sclr), 32'd0);
    check("sa_dim", 32'(gen_img_dim), 32'd0);
    check("sa_incr", 32'(gen_incr), 32'd0);
    step();

    for (int i = 0; i < 5; i++) begin
      run_frame(frames[i], 1'b1);
      step();
    end

    // abort after 7 accepts of a dim=4 frame
    run_accepts(9'd4, 7);
    abort = 1'b1;
    #1;
    check("abort_gen_en", 32'(gen_en), 32'd0);
    check("abort_x", 32'(x_cnt_xp), 32'd2);
    check("abort_y", 32'(y_cnt_xp), 32'd1);
    step();
    abort = 1'b0;
    #1;
    check("flush_sclr", 32'(gen_sclr), 32'd1);
    check("flush_done", 32'(done), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    step();
    #1;
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_done", 32'(done), 32'd0);
    step();
    run_frame(frames[3], 1'b0);
    step();

    // forced coordinates: first accept at dim=1 looks like the last sample
    force_xy = 1'b1;
    start = 1'b1; cfg_img_dim = 9'd1; out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    #1;
    check("force_valid", 32'(out_valid), 32'd1);
    step();
    #1;
    force_xy = 1'b0;
    check("force_done", 32'(done), 32'd1);
    check("force_err", 32'(err), 32'(CHK_ON));
    step();
    #1;
    check("force_err_sticky", 32'(err), 32'(CHK_ON));
    check("force_idle_busy", 32'(busy), 32'd0);
    run_frame(frames[2], 1'b0);
    step();

    // reset in the middle of a dim=5 frame
    run_accepts(9'd5, 10);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_gen_en", 32'(gen_en), 32'd0);
    check("mrst_sclr", 32'(gen_sclr), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    check("mrst_dim", 32'(gen_img_dim), 32'd0);
    check("mrst_incr", 32'(gen_incr), 32'd0);
    step();
    #1;
    check("mrst_done_later", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();
    #1;
    check("mrst_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xp_scan_ctrl.md
Name: xp_scan_ctrl

Overview:
- Frame-level sequencer for the xp_gen coordinate/skew-accumulator datapath in the deskew IP.
- Latches a per-frame configuration (image dimension, increment, offset) into shadow registers and clears the generator.
- Steps the generator one sample per accepted downstream beat with valid/ready backpressure, then signals completion.
- Sits between the register/control interface and xp_gen; one instance per xp_gen.

Parameters:
DIM_W, 9, width of image dimension and x/y counters
ACC_W, 24, width of increment, offset and accumulator

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  frame start request, sampled in IDLE only
abort  in  1  terminate current frame
cfg_img_dim  in  DIM_W  last coordinate index (frame is (dim+1)x(dim+1) samples)
cfg_incr  in  ACC_W  accumulator increment for the frame
cfg_offset  in  ACC_W  accumulator offset for the frame
x_cnt_xp  in  DIM_W  generator x counter
y_cnt_xp  in  DIM_W  generator y counter
out_ready  in  1  downstream accepts current sample
gen_en  out  1  generator step enable
gen_sclr  out  1  generator synchronous clear
gen_img_dim  out  DIM_W  shadowed dimension to generator
gen_incr  out  ACC_W  shadowed increment
gen_offset  out  ACC_W  shadowed offset
out_valid  out  1  generator output is a valid sample
busy  out  1  frame in progress (state != IDLE)
done  out  1  one-cycle pulse at normal frame completion
err  out  1  sticky sample-count mismatch flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, shadow registers 0, err 0.
- FSM states: IDLE, CLEAR, RUN, DONE, FLUSH. All outputs are registered or decoded from state only.
- IDLE:
  - start=1 and abort=0 -> latch cfg_* into shadows, go to CLEAR.
  - abort=1 -> stay IDLE; abort has priority over start in the same cycle.
- CLEAR (1 cycle): gen_sclr=1, gen_en=0, out_valid=0 -> RUN.
- RUN:
  - out_valid=1; gen_en = out_ready (combinational AND with state==RUN).
  - A sample is accepted when out_valid & out_ready.
  - Without ready, the generator holds, so x/y/xp_out stay stable.
  - Last-sample detection: accept with x_cnt_xp==gen_img_dim and y_cnt_xp==gen_img_dim -> DONE.
  - abort=1 -> FLUSH, with no accept counted in that cycle (gen_en forced 0).
- DONE (1 cycle): done=1, gen_en=0, out_valid=0 -> IDLE.
- FLUSH (1 cycle): gen_sclr=1, done stays 0 -> IDLE.
- Every frame costs 1 cycle of CLEAR overhead plus 1 cycle of DONE overhead.
- Latency: with out_ready held 1, done rises (dim+1)^2 + 2 cycles after the start-accept edge.
- busy rises the cycle after start is accepted and falls the cycle after DONE or FLUSH.
- Shadows change only on start-accept in IDLE; cfg_* changes mid-frame have no effect.
- start while busy is ignored and not queued.
- cfg_img_dim=0: the frame is a single sample (0,0); DONE follows on the first accept.
- abort in CLEAR or DONE -> FLUSH; in DONE the done pulse still fires in that cycle.
- Asserting rst_n mid-frame returns to IDLE immediately; shadows are cleared, and there is no done pulse.

Optional Feature:
Macro XP_SCAN_CTRL_CHK_EN.
- Defined:
  - An independent 2*DIM_W-bit sample counter clears in CLEAR and increments on each accept.
  - On entry to DONE, err is set if count != (gen_img_dim+1)^2.
  - err is sticky until the next start-accept or reset. Aborted frames are not checked.
- Not defined: counter absent, err tied 0, and no extra logic.

Decomposition:
- Package deskew_pkg holds:
  - DIM_W=9 and ACC_W=24 defaults;
  - the state encoding (3-bit: IDLE=0, CLEAR=1, RUN=2, DONE=3, FLUSH=4);
  - the SAMPLE_CNT_W=2*DIM_W constant.
- Natural sub-module: scan_sample_chk, the optional accept counter and comparator. Instantiate it only under XP_SCAN_CTRL_CHK_EN.

Test Plan:
- Reset mid-RUN (dim=5, after 10 accepts) -> next cycle all outputs 0, state IDLE, no done.
- dim=3, incr=0x000100, offset=0x000010, out_ready=1:
  - gen_sclr for 1 cycle after start, then 16 accepts;
  - last accept at x=3,y=3; done pulses exactly once at cycle 18 after start; busy drops next cycle.
- dim=2, out_ready toggling 1,0,0,1,...:
  - x/y stay stable whenever ready=0;
  - exactly 9 accepts; done only after 9th accept.
- dim=4, abort asserted after 7 accepts:
  - FLUSH with gen_sclr=1; no done; busy low 2 cycles after abort;
  - a new start with dim=1 gives 4 accepts and done.
- start and abort asserted together in IDLE -> no state change. start pulsed while busy (dim=2) -> ignored, frame completes with 9 accepts. cfg change mid-frame -> gen_* unchanged.
- With XP_SCAN_CTRL_CHK_EN, dim=0:
  - 1 accept, done, err=0;
  - forced x/y mismatch (bench drives x=y=1 on 1st accept at dim=1) -> err=1 at DONE, cleared by next start.
